// File: rtl/wait_gen_pkg.sv
// rtl/wait_gen_pkg.sv - shared types and LFSR constants for the wait-state generator
// Holds the LFSR used by the optional WAIT_RAND_EN random wait extension.
package wait_gen_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        RDY   = 2'd2
    } wg_state_t;

    localparam int              LFSR_W    = 16;
    localparam logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1;
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;
    localparam logic [LFSR_W-1:0] RAND_MASK = 16'h000F;

    // Fibonacci step: feedback is the parity of the tapped bits, shifted in at bit 0.
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
        return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/wait_gen_chan.sv
// rtl/wait_gen_chan.sv - one strobe/ready channel: cfg register, wait counter and FSM
// WAIT_RAND_EN adds a saturating LFSR-based extension of the wait count.
module wait_gen_chan
    import wait_gen_pkg::*;
#(
    parameter int CNT_W         = 12,
    parameter int DEFAULT_WAITS = 5
) (
    input  logic              clk_i,
    input  logic              resetn_i,
    input  logic              strobe_i,
    input  logic              cfg_wr_i,
    input  logic [CNT_W-1:0]  cfg_i,
`ifdef WAIT_RAND_EN
    input  logic              rand_mode_i,
    input  logic [LFSR_W-1:0] lfsr_i,
`endif
    output logic              ready_o,
    output logic              busy_o,
    output logic              abort_o
);

    wg_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cfg_q;
    logic             abort_q, abort_d;
    logic [CNT_W-1:0] w;

`ifdef WAIT_RAND_EN
    logic [CNT_W:0]   rand_sum;
    always_comb begin
        rand_sum = {1'b0, cfg_q} + (CNT_W+1)'(lfsr_i & RAND_MASK);
        w        = cfg_q;
        if (rand_mode_i) begin
            w = rand_sum[CNT_W] ? {CNT_W{1'b1}} : rand_sum[CNT_W-1:0];
        end
    end
`else
    assign w = cfg_q;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        abort_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (strobe_i && (w != '0)) begin
                    cnt_d   = w;
                    state_d = COUNT;
                end
            end
            COUNT: begin
                if (!strobe_i) begin
                    state_d = IDLE;
                    abort_d = 1'b1;
                end else if (cnt_q <= CNT_W'(1)) begin
                    cnt_d   = '0;
                    state_d = RDY;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RDY: begin
                // A zero wait cannot be counted; IDLE serves it combinationally instead.
                if (strobe_i && (w != '0)) begin
                    cnt_d   = w;
                    state_d = COUNT;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            cfg_q   <= CNT_W'(DEFAULT_WAITS);
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            abort_q <= abort_d;
            if (cfg_wr_i) begin
                cfg_q <= cfg_i;
            end
        end
    end

    assign ready_o = ((state_q == IDLE) && (w == '0)) ? strobe_i : (state_q == RDY);
    assign busy_o  = (state_q == COUNT);
    assign abort_o = abort_q;

endmodule

// File: rtl/wait_state_gen.sv
// rtl/wait_state_gen.sv - multi-channel programmable READY / wait-state generator
// WAIT_RAND_EN enables the shared LFSR and per-channel RAND_MODE wait extension.
module wait_state_gen
    import wait_gen_pkg::*;
#(
    parameter int CHANNELS      = 4,
    parameter int CNT_W         = 12,
    parameter int DEFAULT_WAITS = 5
) (
    input  logic                      CLK,
    input  logic                      RESETn,
    input  logic [CHANNELS-1:0]       STROBE,
    input  logic [CHANNELS-1:0]       CFG_WR,
    input  logic [CHANNELS*CNT_W-1:0] WAIT_CFG,
    input  logic [CHANNELS-1:0]       RAND_MODE,
    output logic [CHANNELS-1:0]       READY,
    output logic [CHANNELS-1:0]       BUSY,
    output logic [CHANNELS-1:0]       ABORT
);

`ifdef WAIT_RAND_EN
    logic [LFSR_W-1:0] lfsr_q;

    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_next(lfsr_q);
        end
    end
`else
    logic unused_rand_mode;
    assign unused_rand_mode = ^RAND_MODE;
`endif

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        wait_gen_chan #(
            .CNT_W         (CNT_W),
            .DEFAULT_WAITS (DEFAULT_WAITS)
        ) u_chan (
            .clk_i       (CLK),
            .resetn_i    (RESETn),
            .strobe_i    (STROBE[i]),
            .cfg_wr_i    (CFG_WR[i]),
            .cfg_i       (WAIT_CFG[i*CNT_W +: CNT_W]),
`ifdef WAIT_RAND_EN
            .rand_mode_i (RAND_MODE[i]),
            .lfsr_i      (lfsr_q),
`endif
            .ready_o     (READY[i]),
            .busy_o      (BUSY[i]),
            .abort_o     (ABORT[i])
        );
    end

endmodule
